// File: rtl/ram_responder_pkg.sv
// Shared encodings for the RAM side of the cache memory interface.
package ram_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/ram_responder_if.sv
// Control half of the cache<->RAM interface; the shared data bus is a separate inout.
interface ram_responder_if #(
    parameter int a_width = 8
);
    logic [a_width-1:0] addr;
    logic               rw;
    logic               ce;

    modport master (output addr, rw, ce);
    modport slave  (input  addr, rw, ce);
endinterface

// File: rtl/ram_responder_sat_counter.sv
// Saturating up-counter used for the read/write transaction statistics.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/ram_responder.sv
// Fixed-timing single-port RAM answering the cache's write-back and line-fill cycles.
// state | meaning
// IDLE  | ce low, bus released
// RD    | read transaction in progress, RAM drives the bus
// WR    | write transaction in progress, cache drives the bus
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int    d_width   = 8,
    parameter int    a_width   = 8,
    parameter int    cnt_width = 16,
    parameter string init_file = ""
) (
    input  logic                 clk,
    input  logic                 clr,
    ram_responder_if.slave       bus,
    inout  wire  [d_width-1:0]   data,
    output logic                 active,
    output logic [cnt_width-1:0] rd_cnt,
    output logic [cnt_width-1:0] wr_cnt
);

    state_t             state;
    state_t             state_nxt;
    logic [d_width-1:0] mem [0:(1<<a_width)-1];
    logic [d_width-1:0] rd_data;
    logic               drv_en;
    logic               drive;
    logic               rd_start;
    logic               wr_start;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= IDLE;
            active  <= 1'b0;
            rd_data <= '0;
            drv_en  <= 1'b0;
        end else begin
            state  <= state_nxt;
            active <= bus.ce;
            if (bus.ce && (bus.rw == RW_READ)) begin
                rd_data <= mem[bus.addr];
                drv_en  <= 1'b1;
            end else begin
                drv_en  <= 1'b0;
            end
        end
    end

    // Array is deliberately outside the reset domain so contents survive clr.
    always_ff @(posedge clk) begin
        if (clr && bus.ce && (bus.rw == RW_WRITE)) begin
            mem[bus.addr] <= data;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        rd_start  = 1'b0;
        wr_start  = 1'b0;
        if (bus.ce) begin
            state_nxt = (bus.rw == RW_READ) ? RD : WR;
        end
        rd_start = (state_nxt == RD) && (state != RD);
        wr_start = (state_nxt == WR) && (state != WR);
    end

    // Live ce/rw gate the driver so turnaround never overlaps the cache's drive.
    assign drive = drv_en & bus.ce & (bus.rw == RW_READ);

    for (genvar i = 0; i < d_width; i++) begin : g_bus
        bufif1 u_drv (data[i], rd_data[i], drive);
    end

    sat_counter #(.width(cnt_width)) u_rd_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (rd_start),
        .count (rd_cnt)
    );

    sat_counter #(.width(cnt_width)) u_wr_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (wr_start),
        .count (wr_cnt)
    );

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench: stimulus queues expected read data, a monitor checks the bus.
module tb_ram_responder;
    import ram_responder_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    ram_responder_if #(.a_width(8)) bus ();
    ram_responder_if #(.a_width(8)) bus_s ();

    wire  [7:0]  data;
    wire  [7:0]  data_s;
    logic [7:0]  tb_val;
    logic        active, active_s;
    logic [15:0] rd_cnt, wr_cnt;
    logic [3:0]  rd_cnt_s, wr_cnt_s;

    // The cache model drives whenever the RAM is not expected to.
    assign data   = (!clr || !(bus.ce && bus.rw)) ? tb_val : 8'hzz;
    assign data_s = (bus_s.ce && !bus_s.rw) ? 8'h99 : 8'hzz;

    ram_responder #(.d_width(8), .a_width(8), .cnt_width(16)) dut (
        .clk(clk), .clr(clr), .bus(bus), .data(data),
        .active(active), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    ram_responder #(.d_width(8), .a_width(8), .cnt_width(4)) dut_s (
        .clk(clk), .clr(clr), .bus(bus_s), .data(data_s),
        .active(active_s), .rd_cnt(rd_cnt_s), .wr_cnt(wr_cnt_s)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_exp;
    logic       pend;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic c, input logic r, input logic [7:0] a,
                         input logic [7:0] v, input logic [7:0] e);
        @(posedge clk);
        #1;
        bus.ce   = c;
        bus.rw   = r;
        bus.addr = a;
        tb_val   = v;
        if (c && r && clr) exp_q.push_back(e);
    endtask

    // Monitor: a read sampled at a rising edge is visible on the next falling edge.
    initial begin
        pend    = 1'b0;
        cur_exp = 8'h00;
        forever begin
            @(posedge clk);
            pend = 1'b0;
            if (clr && bus.ce && bus.rw) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
                end else begin
                    cur_exp = exp_q.pop_front();
                    pend    = 1'b1;
                end
            end
            @(negedge clk);
            if (pend) begin
                if (clr && bus.ce && bus.rw) chk("rd_data", 16'(data), 16'(cur_exp));
                else                         chk("bus_release", 16'(data), 16'(tb_val));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ce = 1'b1; bus.rw = 1'b1; bus.addr = 8'h00; tb_val = 8'h5A;
        bus_s.ce = 1'b0; bus_s.rw = 1'b0; bus_s.addr = 8'h00;

        // Reset held with a read presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus",    16'(data),      16'h005A);
        chk("rst_rd_cnt", rd_cnt,         16'h0000);
        chk("rst_wr_cnt", wr_cnt,         16'h0000);
        chk("rst_active", 16'(active),    16'h0000);
        chk("rst_state",  16'(dut.state), 16'(IDLE));
        @(posedge clk);
        #1;
        clr = 1'b1; bus.ce = 1'b0; bus.rw = 1'b0; tb_val = 8'h00;

        // Write A5 to 3C for two cycles, then read it back
        apply(1, 0, 8'h3C, 8'hA5, 8'h00);
        apply(1, 0, 8'h3C, 8'hA5, 8'h00);
        apply(1, 1, 8'h3C, 8'h00, 8'hA5);
        apply(1, 1, 8'h3C, 8'h00, 8'hA5);
        apply(0, 0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("wr_rd_rd_cnt", rd_cnt,      16'd1);
        chk("wr_rd_wr_cnt", wr_cnt,      16'd1);
        chk("wr_rd_active", 16'(active), 16'd1);

        // Preload, write-back, then a fill whose address changes mid-read
        apply(1, 0, 8'h20, 8'h7E, 8'h00);
        apply(1, 0, 8'h20, 8'h7E, 8'h00);
        apply(0, 0, 8'h00, 8'h00, 8'h00);
        apply(1, 0, 8'h10, 8'h11, 8'h00);
        apply(1, 0, 8'h10, 8'h11, 8'h00);
        apply(1, 1, 8'h20, 8'h00, 8'h7E);
        apply(1, 1, 8'h20, 8'h00, 8'h7E);
        apply(1, 1, 8'h10, 8'h00, 8'h11);
        apply(1, 1, 8'h10, 8'h00, 8'h11);
        apply(0, 0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("fill_rd_cnt", rd_cnt, 16'd2);
        chk("fill_wr_cnt", wr_cnt, 16'd3);

        // Turnaround with ce held: read 3C-valued word, flip to write C3, read after write
        apply(1, 0, 8'h40, 8'h3C, 8'h00);
        apply(1, 0, 8'h40, 8'h3C, 8'h00);
        apply(1, 1, 8'h40, 8'h00, 8'h3C);
        apply(1, 1, 8'h40, 8'h00, 8'h3C);
        apply(1, 0, 8'h41, 8'hC3, 8'h00);
        apply(1, 0, 8'h41, 8'hC3, 8'h00);
        apply(1, 1, 8'h41, 8'h00, 8'hC3);
        apply(1, 1, 8'h41, 8'h00, 8'hC3);
        apply(0, 0, 8'h00, 8'h00, 8'h00);
        apply(0, 0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("turn_rd_cnt", rd_cnt,         16'd4);
        chk("turn_wr_cnt", wr_cnt,         16'd5);
        chk("idle_active", 16'(active),    16'd0);
        chk("idle_state",  16'(dut.state), 16'(IDLE));

        // Async reset in the middle of a read
        apply(1, 1, 8'h20, 8'h5A, 8'h7E);
        @(posedge clk);
        #3;
        clr = 1'b0;
        #1;
        chk("arst_bus",    16'(data),      16'h005A);
        chk("arst_state",  16'(dut.state), 16'(IDLE));
        chk("arst_rd_cnt", rd_cnt,         16'd0);
        @(posedge clk);
        #1;
        exp_q.push_back(8'h7E);
        clr = 1'b1;
        apply(1, 1, 8'h20, 8'h5A, 8'h7E);
        apply(1, 1, 8'h3C, 8'h5A, 8'hA5);
        apply(1, 1, 8'h3C, 8'h5A, 8'hA5);
        apply(0, 0, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_rst_rd_cnt", rd_cnt, 16'd1);
        chk("post_rst_wr_cnt", wr_cnt, 16'd0);

        // Saturation on the 4-bit counter instance
        @(posedge clk);
        #1;
        bus_s.ce = 1'b1; bus_s.rw = 1'b0; bus_s.addr = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        bus_s.ce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus_s.ce = 1'b1; bus_s.rw = 1'b1; bus_s.addr = 8'h77;
            @(posedge clk);
            #1;
            @(negedge clk);
            if (i == 0)  chk("sat_rd_data", 16'(data_s),   16'h0099);
            if (i == 13) chk("sat_cnt_14",  16'(rd_cnt_s), 16'h000E);
            if (i == 14) chk("sat_cnt_15",  16'(rd_cnt_s), 16'h000F);
            @(posedge clk);
            #1;
            bus_s.ce = 1'b0;
        end
        @(negedge clk);
        chk("sat_cnt_final", 16'(rd_cnt_s), 16'h000F);
        chk("sat_wr_cnt",    16'(wr_cnt_s), 16'h0001);

        repeat (2) @(posedge clk);
        chk("sb_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
